// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ valid/ready producers share one FIFO write port in bounded bursts.
// Optional per-producer saturating accepted-word counters (grant_cnt port) when ARB_GRANT_CNT_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt
`endif
);

  localparam int OWN_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state, state_next;
  logic [OWN_W-1:0]         last_owner;
  logic [BEAT_W-1:0]        beat_cnt;
  logic [OWN_W-1:0]         pick_idx;
  logic                     pick_found;
  logic [NUM_REQ-1:0]       owner_onehot;
  logic                     owner_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_shifted;
  logic [DATA_WIDTH-1:0]    owner_data;
  logic                     xfer;
  logic                     burst_done;

  assign owner_onehot = NUM_REQ'(1) << owner;
  assign owner_valid  = |(req_valid & owner_onehot);
  assign data_shifted = req_data >> (DATA_WIDTH * int'(owner));
  assign owner_data   = data_shifted[DATA_WIDTH-1:0];
  assign xfer         = (state == BURST) && owner_valid && !fifo_full;
  assign burst_done   = xfer && (beat_cnt == BEAT_W'(MAX_BURST - 1));

  // Rotate the valid vector so the slot after last_owner lands at bit 0, then take the lowest set bit.
  always_comb begin
    logic [OWN_W-1:0]     start;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [OWN_W-1:0]     offset;
    logic [OWN_W:0]       sum;
    start      = (last_owner == OWN_W'(NUM_REQ - 1)) ? '0 : last_owner + OWN_W'(1);
    dbl        = {req_valid, req_valid} >> start;
    rot        = dbl[NUM_REQ-1:0];
    offset     = '0;
    pick_found = |rot;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) offset = OWN_W'(j);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (OWN_W+1)'(NUM_REQ)) sum = sum - (OWN_W+1)'(NUM_REQ);
    pick_idx = sum[OWN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OWN_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_found) begin
        owner    <= pick_idx;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
      if (state == BURST && state_next == IDLE) last_owner <= owner;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_found) state_next = BURST;
      BURST:   if (!owner_valid || burst_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced to their idle values while rst is high so a reset cycle never writes.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    busy         = 1'b0;
    if (!rst && state == BURST) begin
      busy         = 1'b1;
      req_ready    = fifo_full ? '0 : owner_onehot;
      fifo_wr_en   = xfer;
      fifo_wr_data = owner_data;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (xfer && owner == OWN_W'(i) && cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
    end
    assign grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a cycle-level model.
// Checks grant_cnt too when ARB_GRANT_CNT_EN is defined.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*DW-1:0] req_data;
  logic          fifo_full, fifo_wr_en, busy;
  logic [DW-1:0] fifo_wr_data;
  logic [1:0]    owner;
`ifdef ARB_GRANT_CNT_EN
  logic [N*CW-1:0] grant_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit m_busy;
  int m_owner, m_last, m_words;
  int m_cnt[N];

  bit            pv[N];
  logic [DW-1:0] pd[N];
  int            sent[N];
  bit            acc[N];

  logic [DW-1:0] dut_wr[$];
  int            grant_log[$];
  bit            prev_busy = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .owner(owner), .busy(busy)
`ifdef ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rrPick(int last);
    for (int k = 1; k <= N; k++) begin
      if (pv[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_words = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model across the edge.
  task automatic applyStimulus(input bit r, input bit full);
    logic [N-1:0] exp_ready;
    bit           exp_wr;
    logic [DW-1:0] exp_data;
    bit           exp_busy;
    int           p;
    rst = r;
    fifo_full = full;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pv[i];
      req_data[i*DW +: DW] = pd[i];
    end
    #1;
    exp_ready = '0; exp_wr = 0; exp_data = '0; exp_busy = 0;
    if (!r && m_busy) begin
      exp_busy = 1;
      if (!full) exp_ready[m_owner] = 1'b1;
      exp_wr   = pv[m_owner] && !full;
      exp_data = pd[m_owner];
    end
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("wr_en", fifo_wr_en, exp_wr);
    checkOutput("wr_data", fifo_wr_data, exp_data);
    checkOutput("busy", busy, exp_busy);
    checkOutput("owner", owner, m_owner);
`ifdef ARB_GRANT_CNT_EN
    for (int i = 0; i < N; i++) checkOutput($sformatf("grant_cnt%0d", i), grant_cnt[i*CW +: CW], m_cnt[i]);
`endif
    if (fifo_wr_en) dut_wr.push_back(fifo_wr_data);
    if (busy && !prev_busy) grant_log.push_back(int'(owner));
    prev_busy = busy;
    for (int i = 0; i < N; i++) acc[i] = 0;
    if (r) begin
      modelReset();
    end else if (!m_busy) begin
      p = rrPick(m_last);
      if (p >= 0) begin m_busy = 1; m_owner = p; m_words = 0; end
    end else if (!pv[m_owner]) begin
      m_busy = 0; m_last = m_owner;
    end else if (!full) begin
      acc[m_owner] = 1;
      m_words++;
      if (m_cnt[m_owner] < (1 << CW) - 1) m_cnt[m_owner]++;
      if (m_words == MB) begin m_busy = 0; m_last = m_owner; end
    end
    @(posedge clk);
  endtask

  task automatic resetPhase();
    for (int i = 0; i < N; i++) begin pv[i] = 0; pd[i] = '0; sent[i] = 0; acc[i] = 0; end
    repeat (2) begin @(negedge clk); applyStimulus(1, 0); end
    dut_wr.delete();
    grant_log.delete();
  endtask

  initial begin
    bit dropped, did_rst, full;
    rst = 1; fifo_full = 0; req_valid = '0; req_data = '0;
    modelReset();

    // Single producer 2, data 0x10 upward
    resetPhase();
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_busy", busy, 0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (acc[2]) sent[2]++;
      pv[2] = 1; pd[2] = DW'(8'h10 + sent[2]);
      applyStimulus(0, 0);
    end
    checkOutput("a_nwords", dut_wr.size(), 8);
    foreach (dut_wr[k]) checkOutput("a_word", dut_wr[k], 8'h10 + k);

    // All producers continuously valid
    resetPhase();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) sent[i]++;
        pv[i] = 1; pd[i] = DW'((i << 6) | sent[i]);
      end
      applyStimulus(0, 0);
    end
    checkOutput("b_ngrants", grant_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) checkOutput("b_order", grant_log[k], k % N);
    checkOutput("b_nwords", dut_wr.size(), 20);

    // FIFO full for three cycles after two words
    resetPhase();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (acc[1]) sent[1]++;
      pv[1] = (sent[1] < 4); pd[1] = DW'(8'h40 + sent[1]);
      applyStimulus(0, c >= 3 && c <= 5);
    end
    checkOutput("c_nwords", dut_wr.size(), 4);

    // Owner drops valid after one word while producer 3 waits
    resetPhase();
    dropped = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (acc[i]) sent[i]++;
      pv[3] = 1; pd[3] = DW'(8'hC0 + sent[3]);
      pv[0] = 1; pd[0] = DW'(8'h00 + sent[0]);
      if (sent[0] == 1 && !dropped) begin pv[0] = 0; dropped = 1; end
      applyStimulus(0, 0);
    end
    checkOutput("d_ngrants", grant_log.size(), 3);
    for (int k = 0; k < 3 && k < grant_log.size(); k++) checkOutput("d_order", grant_log[k], (k == 1) ? 3 : 0);

    // Reset during the third beat of producer 1's burst
    resetPhase();
    did_rst = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) sent[i]++;
        pv[i] = did_rst ? 1'b1 : (i == 1 || i == 2);
        pd[i] = DW'((i << 6) | sent[i]);
      end
      if (!did_rst && m_busy && m_words == 2) begin
        did_rst = 1;
        grant_log.delete();
        applyStimulus(1, 0);
      end else begin
        applyStimulus(0, 0);
      end
    end
    checkOutput("e_reset_hit", did_rst, 1);
    checkOutput("e_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

`ifdef ARB_GRANT_CNT_EN
    // Saturation of producer 1's counter
    resetPhase();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      pv[1] = 1; pd[1] = DW'(c);
      applyStimulus(0, 0);
    end
    @(negedge clk);
    checkOutput("f_sat1", grant_cnt[1*CW +: CW], 15);
    checkOutput("f_zero0", grant_cnt[0*CW +: CW], 0);
`endif

    // Randomized traffic with random full and occasional reset
    resetPhase();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          pv[i] = bit'($urandom_range(1, 0)); pd[i] = DW'($urandom);
        end else if (pv[i]) begin
          if ($urandom_range(9, 0) == 0) pv[i] = 0;
        end else if ($urandom_range(1, 0) == 1) begin
          pv[i] = 1; pd[i] = DW'($urandom);
        end
      end
      full = ($urandom_range(4, 0) == 0);
      applyStimulus($urandom_range(149, 0) == 0, full);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
